seq_mant_mult: RTL and testbench

Parametrised sequential shift-add multiplier for IEEE-754 significands. Takes two MANT_W-bit fractions, prepends the hidden 1, and produces the full 2N-bit product. It also produces a normalised fraction with guard/round/sticky bits, ready for the rounding stage.
Sits between exponent/sign handling and the rounder in the FP multiply path, and works for single, double or custom formats via MANT_W.

---
 rtl/mult_pkg.sv | 33 +++
 rtl/mult_norm.sv | 31 +++
 rtl/seq_mant_mult.sv | 129 ++++++++++++
 tb/tb_seq_mant_mult.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the significand multipliers: state encoding, default
// sizes and grs bit positions. RADIX4_EN selects the two-bits-per-cycle variant.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MANT_W_DEF = 23;
    localparam int N          = MANT_W_DEF + 1;
    localparam int PROD_W     = 2 * N;
`ifdef RADIX4_EN
    localparam int ITER       = (N + 1) / 2;
`else
    localparam int ITER       = N;
`endif

    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    // Iteration count for an n-bit significand (hidden bit included).
    function automatic int iter_of(input int n);
`ifdef RADIX4_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/mult_norm.sv
// Combinational normaliser: full significand product -> shift flag, fraction
// without hidden bit, and guard/round/sticky for the rounder.
module mult_norm
    import mult_pkg::*;
#(
    parameter int MANT_W = 23
) (
    input  logic [2*(MANT_W+1)-1:0] product_i,
    output logic                    norm_shift_o,
    output logic [MANT_W-1:0]       norm_frac_o,
    output logic [2:0]              grs_o
);

    localparam int SW = MANT_W + 1;
    localparam int PW = 2 * SW;

    // Product aligned so its leading one sits just above bit PW-2.
    logic [PW-2:0] m;

    always_comb begin
        norm_shift_o = product_i[PW-1];
        m            = product_i[PW-1] ? product_i[PW-2:0]
                                       : {product_i[PW-3:0], 1'b0};
        norm_frac_o  = m[PW-2 -: MANT_W];
        grs_o        = '0;
        grs_o[GRS_G] = m[SW-1];
        grs_o[GRS_R] = m[SW-2];
        grs_o[GRS_S] = |m[SW-3:0];
    end

endmodule

// File: rtl/seq_mant_mult.sv
// Sequential shift-add multiplier for IEEE-754 significands with normalised
// output. Define RADIX4_EN to retire two multiplier bits per cycle.
module seq_mant_mult
    import mult_pkg::*;
#(
    parameter int MANT_W = 23,
    parameter int CNT_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MANT_W-1:0]       a_frac,
    input  logic [MANT_W-1:0]       b_frac,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [2*(MANT_W+1)-1:0] product,
    output logic                    norm_shift,
    output logic [MANT_W-1:0]       norm_frac,
    output logic [2:0]              grs
);

    localparam int SW = MANT_W + 1;
    localparam int PW = 2 * SW;
    localparam int IT = iter_of(SW);
`ifdef RADIX4_EN
    localparam int STEP = 2;
    localparam int AW   = 2 * IT;
`else
    localparam int STEP = 1;
    localparam int AW   = SW;
`endif

    state_t             state_q, state_d;
    logic [SW-1:0]      p_q, p_d;
    logic [SW-1:0]      b_q, b_d;
    logic [AW-1:0]      a_q, a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW+STEP-1:0] addend, sum;
    logic [SW+AW-1:0]   pa;
`ifdef RADIX4_EN
    logic [SW+1:0]      b3_q, b3_d;
`endif

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef RADIX4_EN
        b3_d    = b3_q;
`endif
        addend  = '0;
        sum     = '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    a_d     = AW'({1'b1, a_frac});
                    b_d     = {1'b1, b_frac};
                    p_d     = '0;
                    cnt_d   = '0;
`ifdef RADIX4_EN
                    b3_d    = {2'b00, 1'b1, b_frac} + {1'b0, 1'b1, b_frac, 1'b0};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
`ifdef RADIX4_EN
                case (a_q[1:0])
                    2'd1:    addend = {2'b00, b_q};
                    2'd2:    addend = {1'b0, b_q, 1'b0};
                    2'd3:    addend = b3_q;
                    default: addend = '0;
                endcase
`else
                addend = a_q[0] ? {1'b0, b_q} : '0;
`endif
                // Partial product stays below B, so SW bits hold it after the shift.
                sum   = {{STEP{1'b0}}, p_q} + addend;
                p_d   = sum[SW+STEP-1:STEP];
                a_d   = {sum[STEP-1:0], a_q[AW-1:STEP]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IT - 1))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
`ifdef RADIX4_EN
            b3_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
`ifdef RADIX4_EN
            b3_q    <= b3_d;
`endif
        end
    end

    assign pa      = {p_q, a_q};
    assign product = pa[PW-1:0];
    assign ready   = (state_q == IDLE) || (state_q == DONE);
    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);

    mult_norm #(.MANT_W(MANT_W)) u_norm (
        .product_i    (product),
        .norm_shift_o (norm_shift),
        .norm_frac_o  (norm_frac),
        .grs_o        (grs)
    );

endmodule

// File: tb/tb_seq_mant_mult.sv
// Directed-vector bench for seq_mant_mult at MANT_W=23 (both radix builds).
module tb_seq_mant_mult;

    localparam int MW = 23;
`ifdef RADIX4_EN
    localparam int IT = 12;
`else
    localparam int IT = 24;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [MW-1:0] a_frac, b_frac;
    logic          ready, busy, done;
    logic [47:0]   product;
    logic          norm_shift;
    logic [MW-1:0] norm_frac;
    logic [2:0]    grs;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mant_mult #(.MANT_W(MW), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_frac     (a_frac),
        .b_frac     (b_frac),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .norm_shift (norm_shift),
        .norm_frac  (norm_frac),
        .grs        (grs)
    );

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [47:0]   p;
        logic          sh;
        logic [MW-1:0] f;
        logic [2:0]    g;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present operands with start; accepted at the next rising edge.
    task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b);
        a_frac = a;
        b_frac = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Edges after the accept edge until done is seen; 100 means timeout.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_product"}, 64'(product), 64'h0);
        chk({tag, "_shift"},   64'(norm_shift), 64'h0);
        chk({tag, "_frac"},    64'(norm_frac), 64'h0);
        chk({tag, "_grs"},     64'(grs), 64'h0);
        chk({tag, "_ready"},   64'(ready), 64'h1);
        chk({tag, "_busy"},    64'(busy), 64'h0);
        chk({tag, "_done"},    64'(done), 64'h0);
    endtask

    initial begin
        int n, n2, ndone;
        logic [47:0] cap;

        vt[0] = '{23'h000000, 23'h000000, 48'h4000_0000_0000, 1'b0, 23'h000000, 3'b000};
        vt[1] = '{23'h7FFFFF, 23'h7FFFFF, 48'hFFFF_FE00_0001, 1'b1, 23'h7FFFFE, 3'b001};
        vt[2] = '{23'h400000, 23'h400000, 48'h9000_0000_0000, 1'b1, 23'h100000, 3'b000};
        vt[3] = '{23'h400000, 23'h000000, 48'h6000_0000_0000, 1'b0, 23'h400000, 3'b000};
        vt[4] = '{23'h000000, 23'h000001, 48'h4000_0080_0000, 1'b0, 23'h000001, 3'b000};
        vt[5] = '{23'h000001, 23'h000001, 48'h4000_0100_0001, 1'b0, 23'h000002, 3'b001};
        vt[6] = '{23'h400000, 23'h000001, 48'h6000_00C0_0000, 1'b0, 23'h400001, 3'b100};
        vt[7] = '{23'h7FFFFF, 23'h000001, 48'h8000_007F_FFFF, 1'b1, 23'h000000, 3'b011};

        rst    = 1'b0;
        start  = 1'b0;
        a_frac = '0;
        b_frac = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            issue(vt[i].a, vt[i].b);
            chk($sformatf("v%0d_busy", i),  64'(busy), 64'h1);
            chk($sformatf("v%0d_ready", i), 64'(ready), 64'h0);
            wait_done(n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'(IT));
            chk($sformatf("v%0d_product", i), 64'(product), 64'(vt[i].p));
            chk($sformatf("v%0d_shift", i),   64'(norm_shift), 64'(vt[i].sh));
            chk($sformatf("v%0d_frac", i),    64'(norm_frac), 64'(vt[i].f));
            chk($sformatf("v%0d_grs", i),     64'(grs), 64'(vt[i].g));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i), 64'(done), 64'h0);
            chk($sformatf("v%0d_hold", i),  64'(product), 64'(vt[i].p));
        end

        // start pulses mid-calculation must be ignored
        issue(23'h400000, 23'h400000);
        ndone = 0;
        cap   = '0;
        for (int k = 1; k <= IT + 4; k++) begin
            if (k == 5 || k == 10) begin
                a_frac = 23'h7FFFFF;
                b_frac = 23'h7FFFFF;
                start  = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                cap = product;
            end
        end
        chk("ignore_done_count", 64'(ndone), 64'h1);
        chk("ignore_product", 64'(cap), 64'h9000_0000_0000);

        // reset in the middle of a calculation
        issue(23'h7FFFFF, 23'h7FFFFF);
        repeat (IT / 2 - 1) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(23'h000000, 23'h000000);
        wait_done(n);
        chk("midrst_latency", 64'(n), 64'(IT));
        chk("midrst_product", 64'(product), 64'h4000_0000_0000);
        chk("midrst_grs", 64'(grs), 64'h0);

        // back-to-back: start accepted in the DONE cycle
        issue(23'h7FFFFF, 23'h7FFFFF);
        wait_done(n);
        chk("b2b_first_product", 64'(product), 64'hFFFF_FE00_0001);
        issue(23'h400000, 23'h400000);
        chk("b2b_accept_busy", 64'(busy), 64'h1);
        wait_done(n2);
        chk("b2b_gap", 64'(n2 + 1), 64'(IT + 1));
        chk("b2b_second_product", 64'(product), 64'h9000_0000_0000);
        chk("b2b_second_frac", 64'(norm_frac), 64'h100000);

        // result held stable while idle, operand changes have no effect
        a_frac = 23'h123456;
        b_frac = 23'h654321;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_product", 64'(product), 64'h9000_0000_0000);
        chk("idle_ready", 64'(ready), 64'h1);
        chk("idle_done", 64'(done), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
